// File: rtl/reorder_scoreboard.sv
// reorder_scoreboard: in-order allocation buffer with register hazard lookup, out-of-order finish, in-order retire and flush
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   push_valid/ready, push_*        allocate a new youngest entry (id, rd, rs1, rs2, wr)
//   rs1/rs2_busy, rs1/rs2_tag       youngest unfinished producer of push_rs1/push_rs2
//   finish_valid, finish_id         mark matching entries done
//   flush_valid, flush_id           squash matching entry and everything younger
//   commit, head_*                  retire the oldest entry once it is done
//   count, full, empty, err         occupancy and sticky protocol-error flag
module reorder_scoreboard #(
  parameter int DEPTH = 16,
  parameter int ID_W  = 32,
  parameter int REG_W = 5
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_valid,
  output logic                       push_ready,
  input  logic [ID_W-1:0]            push_id,
  input  logic [REG_W-1:0]           push_rd,
  input  logic [REG_W-1:0]           push_rs1,
  input  logic [REG_W-1:0]           push_rs2,
  input  logic                       push_wr,
  output logic                       rs1_busy,
  output logic                       rs2_busy,
  output logic [ID_W-1:0]            rs1_tag,
  output logic [ID_W-1:0]            rs2_tag,
  input  logic                       finish_valid,
  input  logic [ID_W-1:0]            finish_id,
  input  logic                       flush_valid,
  input  logic [ID_W-1:0]            flush_id,
  input  logic                       commit,
  output logic                       head_valid,
  output logic                       head_done,
  output logic [ID_W-1:0]            head_id,
  output logic [REG_W-1:0]           head_rd,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty,
  output logic                       err
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  logic [DEPTH-1:0] valid_q, valid_d, done_q, done_d, wr_q, wr_d;
  logic [REG_W-1:0] rd_q [DEPTH];
  logic [REG_W-1:0] rd_d [DEPTH];
  logic [ID_W-1:0]  id_q [DEPTH];
  logic [ID_W-1:0]  id_d [DEPTH];
  logic [PW-1:0]    head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]    count_q, count_d;
  logic             err_q, err_d;
  logic [PW-1:0]    h_idx, s_idx, fl_idx, fl_dist;
  logic             fin_hit, fl_hit, do_commit, do_push;
  assign full       = count_q == FULL_CNT;
  assign empty      = count_q == '0;
  assign push_ready = !full && !flush_valid;
  assign head_valid = !empty;
  assign head_done  = !empty && done_q[head_q];
  assign head_id    = empty ? '0 : id_q[head_q];
  assign head_rd    = empty ? '0 : rd_q[head_q];
  assign count      = count_q;
  assign err        = err_q;
  // Walking oldest to youngest lets the last match win, giving the youngest producer.
  always_comb begin
    rs1_busy = 1'b0;
    rs2_busy = 1'b0;
    rs1_tag  = '0;
    rs2_tag  = '0;
    h_idx    = '0;
    for (int k = 0; k < DEPTH; k++) begin
      h_idx = head_q + PW'(k);
      if (valid_q[h_idx] && wr_q[h_idx] && !done_q[h_idx] && push_rs1 != '0 && rd_q[h_idx] == push_rs1) begin
        rs1_busy = 1'b1;
        rs1_tag  = id_q[h_idx];
      end
      if (valid_q[h_idx] && wr_q[h_idx] && !done_q[h_idx] && push_rs2 != '0 && rd_q[h_idx] == push_rs2) begin
        rs2_busy = 1'b1;
        rs2_tag  = id_q[h_idx];
      end
    end
  end
  always_comb begin
    valid_d = valid_q;
    done_d  = done_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    id_d    = id_q;
    head_d  = head_q;
    tail_d  = tail_q;
    err_d   = err_q;
    fin_hit = 1'b0;
    fl_hit  = 1'b0;
    fl_idx  = '0;
    s_idx   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (finish_valid && valid_q[i] && id_q[i] == finish_id) begin
        done_d[i] = 1'b1;
        fin_hit   = 1'b1;
      end
    end
    if (finish_valid && !fin_hit) err_d = 1'b1;
    // Commit sees this cycle's finish, so finishing and retiring the head together works.
    do_commit = commit && !empty && done_d[head_q];
    if (commit && !do_commit) err_d = 1'b1;
    if (do_commit) begin
      valid_d[head_q] = 1'b0;
      done_d[head_q]  = 1'b0;
      head_d          = head_q + PW'(1);
    end
    do_push = push_valid && push_ready;
    if (do_push) begin
      valid_d[tail_q] = 1'b1;
      done_d[tail_q]  = 1'b0;
      wr_d[tail_q]    = push_wr;
      rd_d[tail_q]    = push_rd;
      id_d[tail_q]    = push_id;
      tail_d          = tail_q + PW'(1);
    end
    count_d = count_q + CW'(do_push) - CW'(do_commit);
    // Scan youngest to oldest so the oldest matching entry is the flush point.
    for (int k = DEPTH - 1; k >= 0; k--) begin
      s_idx = head_q + PW'(k);
      if (valid_q[s_idx] && id_q[s_idx] == flush_id) begin
        fl_hit = 1'b1;
        fl_idx = s_idx;
      end
    end
    fl_dist = fl_idx - head_q;
    if (flush_valid && !fl_hit) err_d = 1'b1;
    if (flush_valid && fl_hit) begin
      for (int k = 0; k < DEPTH; k++) begin
        s_idx = head_q + PW'(k);
        if (PW'(k) >= fl_dist) begin
          valid_d[s_idx] = 1'b0;
          done_d[s_idx]  = 1'b0;
        end
      end
      // Flushing the entry being committed leaves the buffer empty at the new head.
      tail_d  = (fl_dist == '0) ? head_d : fl_idx;
      count_d = (fl_dist == '0) ? '0 : CW'(fl_dist) - CW'(do_commit);
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      done_q  <= '0;
      wr_q    <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        rd_q[i] <= '0;
        id_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      done_q  <= done_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      id_q    <= id_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end
endmodule
